// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: ISA opcodes, FSM
// encoding and program-word field layout.
package instr_sequencer_pkg;

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NOP  = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;

    localparam logic [7:0] NOP_BYTE = {OP_NOP, 4'b0000};

    localparam int WORD_W  = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int R1_HI   = 11;
    localparam int R1_LO   = 8;
    localparam int BYTE_HI = 7;
    localparam int BYTE_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_HI-OP_LO:0]     op;
        logic [R1_HI-R1_LO:0]     r1;
        logic [BYTE_HI-BYTE_LO:0] data;
    } word_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Load port (valid/ready) and issue bus between the program source,
// the sequencer and the CPU core.
interface instr_sequencer_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_word;
    logic        issue_valid;
    logic [7:0]  issue_inst;
    logic [7:0]  issue_data;

    modport master (
        output load_valid, load_word,
        input  load_ready, issue_valid, issue_inst, issue_data
    );

    modport slave (
        input  load_valid, load_word,
        output load_ready, issue_valid, issue_inst, issue_data
    );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program storage: synchronous write, asynchronous read, no reset.
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_sequencer.sv
// Captures a short program over the load port and replays it into the
// core one word per cycle (run, loop or single-step).
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    bus,
    input  logic                run_i,
    input  logic                step_i,
    input  logic                halt_req_i,
    input  logic                clear_i,
    input  logic                loop_en_i,
    output logic [AW-1:0]       pc_o,
    output logic [AW:0]         count_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int CW = AW + 1;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   count_q;
    logic          issue_valid_q;
    logic [7:0]    issue_inst_q;
    logic [7:0]    issue_data_q;

    logic          load_ready;
    logic          load_fire;
    logic          mem_we;
    logic          has_prog;
    logic          last;
    logic [AW-1:0] pc_wrap;
    logic [15:0]   rdata;
    word_t         cur;

    assign load_ready = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
    assign load_fire  = bus.load_valid && load_ready;
    // A clear in the same cycle wins over the handshake, so nothing is written.
    assign mem_we     = load_fire && !clear_i;
    assign has_prog   = (count_q != '0);
    assign last       = ({1'b0, pc_q} == (count_q - CW'(1)));
    assign pc_wrap    = last ? '0 : pc_q + AW'(1);
    assign cur        = word_t'(rdata);

    seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.load_word),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_inst_q  <= NOP_BYTE;
            issue_data_q  <= 8'h00;
        end else begin
            issue_valid_q <= 1'b0;
            issue_inst_q  <= NOP_BYTE;
            issue_data_q  <= 8'h00;
            unique case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        count_q <= '0;
                        pc_q    <= '0;
                    end else if (load_fire) begin
                        count_q <= count_q + CW'(1);
                    end else if (run_i && has_prog) begin
                        state_q <= ST_RUN;
                        pc_q    <= '0;
                    end else if (step_i && has_prog) begin
                        issue_valid_q <= 1'b1;
                        issue_inst_q  <= {cur.op, cur.r1};
                        issue_data_q  <= cur.data;
                        pc_q          <= pc_wrap;
                    end
                end
                ST_RUN: begin
                    if (halt_req_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        issue_valid_q <= 1'b1;
                        issue_inst_q  <= {cur.op, cur.r1};
                        issue_data_q  <= cur.data;
                        pc_q          <= pc_wrap;
                        if (last && !loop_en_i) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (clear_i) begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                        pc_q    <= '0;
                    end else if (run_i) begin
                        state_q <= ST_RUN;
                        pc_q    <= '0;
                    end else if (halt_req_i) begin
                        state_q <= ST_IDLE;
                        pc_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_inst  = issue_inst_q;
    assign bus.issue_data  = issue_data_q;
    assign pc_o            = pc_q;
    assign count_o         = count_q;
    assign busy_o          = (state_q == ST_RUN);
    assign done_o          = (state_q == ST_DONE);
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 8-bit CPU core.
- Captures a short program of 16-bit instruction words through a valid/ready load port and stores them in a local program memory.
- Replays the program into the core's instruction inputs one word per cycle, in run, loop or single-step mode.
- Drives the core's opcode/R1 byte and its R2/R3/data byte. Emits the NOP encoding whenever no instruction is being issued.

Parameters:
- DEPTH, 16, number of program words stored (power of 2, at least 2).
- AW, 4, address width, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load word offered.
- load_ready  out  1  sequencer accepts a load word this cycle.
- load_word  in  16  {op[3:0], r1[3:0], byte[7:0]}.
- run  in  1  pulse: start execution from pc 0.
- step  in  1  pulse: issue exactly one instruction at pc.
- halt_req  in  1  pulse: stop execution.
- clear  in  1  pulse: discard the stored program.
- loop_en  in  1  level: wrap to pc 0 after the last word instead of finishing.
- issue_valid  out  1  issue_inst/issue_data hold a real program word.
- issue_inst  out  8  to core opcode/R1 input, = word[15:8].
- issue_data  out  8  to core R2/R3/data input, = word[7:0].
- pc  out  AW  index of the next word to issue.
- count  out  AW+1  number of words loaded.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Reset values: state IDLE, pc 0, count 0, issue_valid 0, issue_inst 8'h40 (NOP), issue_data 8'h00.
- Memory contents are not reset; they are meaningless while count is 0.
- issue_valid, issue_inst and issue_data are registered.
- An instruction accepted or fetched at edge N is visible on the outputs after edge N and is held for exactly one cycle.
- In any cycle that issues nothing, the outputs return to issue_valid 0, issue_inst 8'h40, issue_data 8'h00.
- load_ready = (state == IDLE) && (count < DEPTH).
- Load handshake fires when load_valid && load_ready: mem[count] <= load_word, count <= count + 1.
- When full, load_ready is 0 and offered words are held off without loss.
- State IDLE, priority order:
  - clear: count <= 0, pc <= 0.
  - Load handshake: run and step are ignored that cycle.
  - run with count > 0: go to RUN, pc <= 0.
  - step with count > 0: issue mem[pc]; pc <= pc + 1, or 0 when pc == count - 1.
  - run or step with count == 0: ignored.
- State RUN, priority order:
  - halt_req: go to IDLE, no issue that edge, pc retained.
  - Otherwise issue mem[pc] every edge:
    - pc < count - 1: pc <= pc + 1.
    - pc == count - 1 and loop_en: pc <= 0, stay in RUN.
    - pc == count - 1 and not loop_en: pc <= 0, go to DONE.
  - clear, step, run and load are ignored.
- State DONE, priority order:
  - clear: go to IDLE, count <= 0, pc <= 0.
  - run: go to RUN, pc <= 0.
  - halt_req: go to IDLE, pc 0, program kept.
  - step is ignored.
- Run latency: run at edge N; mem[0] appears after edge N+1; mem[k] appears after edge N+1+k. Words are issued back to back with no bubbles.
- loop_en is sampled only at the last-word edge.
- Reset mid-run: outputs go to NOP immediately (asynchronous), count goes to 0, and the stored program is lost.

Decomposition:
- Shared package holds:
  - ISA opcode constants, including OP_NOP = 4'b0100; NOP byte = {OP_NOP, 4'b0}.
  - State encoding: IDLE, RUN, DONE (2 bits).
  - Word field slice positions.
- One sub-module: seq_prog_mem, DEPTH x 16 storage with synchronous write and asynchronous read, no reset.

Test Plan:
- Reset, then check outputs: issue_inst 8'h40, issue_data 0, issue_valid 0, count 0, load_ready 1.
- Load 16'h1105, 16'h1203, 16'hB312, pulse run → consecutive cycles show 11/05, 12/03, B3/12 with issue_valid 1; then NOP, done 1, pc 0.
- Same program with loop_en = 1, pulse run, halt_req after 5 issued words → sequence 1105, 1203, B312, 1105, 1203; then state IDLE, pc 2, no further issue.
- In IDLE, step ×4 on the 3-word program → 1105, 1203, B312, 1105, each for one cycle with NOP between; pc wraps 0 → 1 → 2 → 0 → 1.
- Load 16 words, then keep load_valid high → load_ready 0 at count 16, no overwrite; clear then run → run ignored (count 0), still IDLE.
- Assert rst during RUN at the second issue → outputs NOP immediately, count 0; run afterwards is ignored.
